// File: rtl/sr_pkg.sv
// Shared constants for the SR flop drive sequencer: FSM encodings, direction codes, defaults.
package sr_pkg;

    localparam int unsigned PULSE_W_DEF = 2;
    localparam int unsigned GAP_W_DEF   = 1;
    localparam int unsigned CNT_W_DEF   = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_CHECK = 2'd3;

    localparam logic DIR_SET = 1'b1;
    localparam logic DIR_CLR = 1'b0;

endpackage

// File: rtl/sr_drive_sequencer_if.sv
// Command/status bundle between a requester and the SR drive sequencer.
interface sr_drive_sequencer_if
    import sr_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             set_req;
    logic             clr_req;
    logic             cmd_ready;
    logic             s;
    logic             r;
    logic             q_fb;
    logic             q_exp;
    logic             q_valid;
    logic             done;
    logic             illegal_cmd;
    logic             mismatch;
    logic [CNT_W-1:0] cmd_cnt;

    modport master (
        output set_req, clr_req, q_fb,
        input  cmd_ready, s, r, q_exp, q_valid, done, illegal_cmd, mismatch, cmd_cnt
    );

    modport slave (
        input  set_req, clr_req, q_fb,
        output cmd_ready, s, r, q_exp, q_valid, done, illegal_cmd, mismatch, cmd_cnt
    );
endinterface

// File: rtl/sr_phase_timer.sv
// Loadable down-counter that parks at zero; shared by the DRIVE and GAP phases.
module sr_phase_timer
    import sr_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_c_o
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c_o = (count_q == '0);
endmodule

// File: rtl/sr_drive_sequencer.sv
// Turns set/clear requests into exclusive, width-limited S/R pulses and checks the flop afterwards.
module sr_drive_sequencer
    import sr_pkg::*;
#(
    parameter int unsigned PULSE_W = PULSE_W_DEF,
    parameter int unsigned GAP_W   = GAP_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    sr_drive_sequencer_if.slave  bus_if
);
    logic [1:0]       state_q, state_d;
    logic             dir_q, dir_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;
    logic             q_exp_q, q_exp_d;
    logic             q_valid_q, q_valid_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             tmr_load_c;
    logic [CNT_W-1:0] tmr_val_c;
    logic             tmr_zero_c;

    sr_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load_c),
        .load_val_i (tmr_val_c),
        .zero_c_o   (tmr_zero_c)
    );

    // Timer is loaded with N-1 so that a phase lasts exactly N cycles.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        s_d        = s_q;
        r_d        = r_q;
        done_d     = 1'b0;
        illegal_d  = 1'b0;
        q_exp_d    = q_exp_q;
        q_valid_d  = q_valid_q;
        mismatch_d = mismatch_q;
        cnt_d      = cnt_q;
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus_if.set_req && bus_if.clr_req) begin
                    illegal_d = 1'b1;
                end else if (bus_if.set_req || bus_if.clr_req) begin
                    dir_d      = bus_if.set_req ? DIR_SET : DIR_CLR;
                    s_d        = bus_if.set_req;
                    r_d        = ~bus_if.set_req;
                    state_d    = ST_DRIVE;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = CNT_W'(PULSE_W - 1);
                end
            end
            ST_DRIVE: begin
                if (tmr_zero_c) begin
                    s_d        = 1'b0;
                    r_d        = 1'b0;
                    state_d    = ST_GAP;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = CNT_W'(GAP_W - 1);
                end
            end
            ST_GAP: begin
                if (tmr_zero_c) begin
                    state_d = ST_CHECK;
                    done_d  = 1'b1;
                end
            end
            ST_CHECK: begin
                q_exp_d   = dir_q;
                q_valid_d = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (bus_if.q_fb != dir_q) begin
                    mismatch_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = 1'b0;
                r_d     = 1'b0;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_CLR;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            q_exp_q    <= 1'b0;
            q_valid_q  <= 1'b0;
            mismatch_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            s_q        <= s_d;
            r_q        <= r_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
            q_exp_q    <= q_exp_d;
            q_valid_q  <= q_valid_d;
            mismatch_q <= mismatch_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus_if.cmd_ready   = ready_q;
    assign bus_if.s           = s_q;
    assign bus_if.r           = r_q;
    assign bus_if.done        = done_q;
    assign bus_if.illegal_cmd = illegal_q;
    assign bus_if.q_exp       = q_exp_q;
    assign bus_if.q_valid     = q_valid_q;
    assign bus_if.mismatch    = mismatch_q;
    assign bus_if.cmd_cnt     = cnt_q;
endmodule
